// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// The BRANCH_NE state exists unconditionally; it is reachable only when MC_BNE_EN is defined.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEMADR    = 4'd2,
        MEMRD     = 4'd3,
        MEMWB     = 4'd4,
        MEMWR     = 4'd5,
        EXECUTE   = 4'd6,
        ALUWB     = 4'd7,
        BRANCH    = 4'd8,
        ADDIEX    = 4'd9,
        ADDIWB    = 4'd10,
        JUMP      = 4'd11,
        BRANCH_NE = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps ALUOp and the R-type funct field to the 3-bit ALU operation.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM sequencing datapath enables per instruction.
// Optional macro MC_BNE_EN adds bne support through the BRANCH_NE state.
module mc_controller
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal_op
);

    logic [STATE_W-1:0] state_q;
    state_t             state, state_d;
    logic               illegal;

    assign state = state_t'(state_q[$bits(state_t)-1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= STATE_W'(FETCH);
        else       state_q <= STATE_W'(state_d);
    end

    always_comb begin
        state_d = FETCH;
        illegal = 1'b0;
        case (state)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = BRANCH_NE;
`endif
                    default:      illegal = 1'b1;
                endcase
            end
            MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    logic    pc_write, branch, branch_ne;
    logic    ir_write_s, reg_write_s, mem_write_s, done_s, illegal_s;
    alu_op_t alu_op;

    always_comb begin
        pc_write    = 1'b0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        done_s      = 1'b0;
        illegal_s   = 1'b0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        pc_src      = PCSRC_ALU;
        alu_op      = ALUOP_ADD;
        case (state)
            FETCH: begin
                ir_write_s = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = SRCB_FOUR;
            end
            DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                done_s    = illegal;
                illegal_s = illegal;
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
                done_s      = 1'b1;
            end
            MEMWR: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
                done_s      = 1'b1;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            BRANCH, BRANCH_NE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                branch    = (state == BRANCH);
                branch_ne = (state == BRANCH_NE);
                pc_src    = PCSRC_ALUOUT;
                done_s    = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ADDIWB: begin
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
                done_s   = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset forces FETCH, whose enables must still stay low while reset is held.
    assign pc_en      = ~reset & (pc_write | (branch & zero) | (branch_ne & ~zero));
    assign ir_write   = ~reset & ir_write_s;
    assign reg_write  = ~reset & reg_write_s;
    assign mem_write  = ~reset & mem_write_s;
    assign instr_done = ~reset & done_s;
    assign illegal_op = ~reset & illegal_s;

    mc_alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by cycle.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       instr_done, illegal_op;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_src(pc_src), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    // Packs expected outputs in a fixed order: pe io mw ir rd mr rw sa sb ac ps dn il.
    function automatic logic [17:0] v(input logic pe, io, mw, ir, rd, mr, rw, sa,
                                      input logic [1:0] sb, input logic [2:0] ac,
                                      input logic [1:0] ps, input logic dn, il);
        return {pe, io, mw, ir, rd, mr, rw, sa, sb, ac, ps, dn, il};
    endfunction

    wire [17:0] obs = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                       alu_src_a, alu_src_b, alu_control, pc_src, instr_done, illegal_op};

    localparam logic [17:0] V_FETCH   = 18'b1_0_0_1_0_0_0_0_01_010_00_0_0;
    localparam logic [17:0] V_RST     = 18'b0_0_0_0_0_0_0_0_01_010_00_0_0;
    localparam logic [17:0] V_DECODE  = 18'b0_0_0_0_0_0_0_0_11_010_00_0_0;
    localparam logic [17:0] V_DEC_ILL = 18'b0_0_0_0_0_0_0_0_11_010_00_1_1;
    localparam logic [17:0] V_MEMADR  = 18'b0_0_0_0_0_0_0_1_10_010_00_0_0;
    localparam logic [17:0] V_MEMRD   = 18'b0_1_0_0_0_0_0_0_00_010_00_0_0;
    localparam logic [17:0] V_MEMWB   = 18'b0_0_0_0_0_1_1_0_00_010_00_1_0;
    localparam logic [17:0] V_MEMWR   = 18'b0_1_1_0_0_0_0_0_00_010_00_1_0;
    localparam logic [17:0] V_ALUWB   = 18'b0_0_0_0_1_0_1_0_00_010_00_1_0;
    localparam logic [17:0] V_ADDIEX  = 18'b0_0_0_0_0_0_0_1_10_010_00_0_0;
    localparam logic [17:0] V_ADDIWB  = 18'b0_0_0_0_0_0_1_0_00_010_00_1_0;
    localparam logic [17:0] V_JUMP    = 18'b1_0_0_0_0_0_0_0_00_010_10_1_0;

    task automatic chk(input string tag, input logic [17:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check the current state's outputs, then advance one cycle to the next negedge.
    task automatic step(input string tag, input logic [17:0] exp);
        #1 chk(tag, exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
        @(negedge clk);
        step("rst_c1", V_RST);
        step("rst_c2", V_RST);
        step("rst_c3", V_RST);
        reset = 1'b0;

        // lw: 5 cycles, done only in MEMWB
        op = 6'b100011;
        step("lw_fetch", V_FETCH);
        step("lw_decode", V_DECODE);
        step("lw_memadr", V_MEMADR);
        step("lw_memrd", V_MEMRD);
        step("lw_memwb", V_MEMWB);

        // R-type slt
        op = 6'b000000; funct = 6'b101010;
        step("slt_fetch", V_FETCH);
        step("slt_decode", V_DECODE);
        step("slt_exec", v(0,0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0,0));
        step("slt_aluwb", V_ALUWB);

        // R-type and, then unknown funct falling back to add
        funct = 6'b100100;
        step("and_fetch", V_FETCH);
        step("and_decode", V_DECODE);
        step("and_exec", v(0,0,0,0,0,0,0,1,2'b00,3'b000,2'b00,0,0));
        step("and_aluwb", V_ALUWB);
        funct = 6'b111111;
        step("unk_fetch", V_FETCH);
        step("unk_decode", V_DECODE);
        step("unk_exec", v(0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,0));
        step("unk_aluwb", V_ALUWB);

        // beq taken then not taken
        op = 6'b000100; zero = 1'b1;
        step("beq1_fetch", V_FETCH);
        step("beq1_decode", V_DECODE);
        step("beq1_branch", v(1,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0));
        zero = 1'b0;
        step("beq0_fetch", V_FETCH);
        step("beq0_decode", V_DECODE);
        step("beq0_branch", v(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0));

        // addi and j
        op = 6'b001000;
        step("addi_fetch", V_FETCH);
        step("addi_decode", V_DECODE);
        step("addi_ex", V_ADDIEX);
        step("addi_wb", V_ADDIWB);
        op = 6'b000010;
        step("j_fetch", V_FETCH);
        step("j_decode", V_DECODE);
        step("j_jump", V_JUMP);

        // illegal opcode: 2 cycles, pulse in DECODE
        op = 6'b111111;
        step("ill_fetch", V_FETCH);
        step("ill_decode", V_DEC_ILL);

        op = 6'b000101; zero = 1'b0;
        step("bne_fetch", V_FETCH);
`ifdef MC_BNE_EN
        step("bne_decode", V_DECODE);
        step("bne_branch", v(1,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0));
        zero = 1'b1;
        step("bne_fetch2", V_FETCH);
        step("bne_decode2", V_DECODE);
        step("bne_branch_z", v(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0));
`else
        step("bne_decode_ill", V_DEC_ILL);
`endif

        // sw interrupted by reset in MEMWR
        op = 6'b101011; zero = 1'b0;
        step("sw_fetch", V_FETCH);
        step("sw_decode", V_DECODE);
        step("sw_memadr", V_MEMADR);
        #1 chk("sw_memwr", V_MEMWR);
        #1 reset = 1'b1;
        #1 chk("sw_rst_async", V_RST);
        @(posedge clk);
        @(negedge clk);
        step("sw_rst_hold", V_RST);
        reset = 1'b0;
        step("sw_restart_fetch", V_FETCH);
        step("sw_restart_decode", V_DECODE);
        step("sw_restart_memadr", V_MEMADR);
        step("sw_restart_memwr", V_MEMWR);
        step("after_sw_fetch", V_FETCH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
